// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball flipper input path.
// Holds the per-channel flip request state encoding.
package pinball_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } flipState_t;

endpackage

// File: rtl/flip_button_channel.sv
// One flipper button channel: synchronizer, debouncer, press detector,
// and the IDLE/ACTIVE/COOLDOWN request FSM with hold and cooldown timers.
module flip_button_channel
    import pinball_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_MAX_CYCLES = 50000000,
    parameter int COOLDOWN_CYCLES = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_move,
    output logic o_timeout
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_MAX_CYCLES) + 1;
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb;
    logic              r_debPrev;
    logic [DEB_W-1:0]  r_debCnt;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [COOL_W-1:0] r_coolCnt;
    logic              r_timeout;
    flipState_t        r_state;
    flipState_t        w_nextState;
    logic              w_press;
    logic              w_holdExpired;
    logic              w_timeoutDrop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_debPrev <= 1'b0;
            r_debCnt  <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_debPrev <= r_deb;
            if (r_sync2 != r_deb) begin
                if (r_debCnt == DEB_LAST) begin
                    r_deb    <= ~r_deb;
                    r_debCnt <= '0;
                end else begin
                    r_debCnt <= r_debCnt + 1'b1;
                end
            end else begin
                r_debCnt <= '0;
            end
        end
    end

    assign w_press       = r_deb & ~r_debPrev;
    assign w_holdExpired = (r_holdCnt == HOLD_LAST);
    // A release wins over an expiring hold timer, so no timeout pulse then.
    assign w_timeoutDrop = (r_state == ACTIVE) && r_deb && w_holdExpired;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_press) w_nextState = ACTIVE;
            ACTIVE:   if (!r_deb || w_holdExpired) w_nextState = COOLDOWN;
            COOLDOWN: if (r_coolCnt == COOL_LAST) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_holdCnt <= '0;
            r_coolCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_timeout <= w_timeoutDrop;
            // Timers only advance while staying in their own state, so they cannot wrap.
            if (r_state == ACTIVE && w_nextState == ACTIVE) begin
                r_holdCnt <= r_holdCnt + 1'b1;
            end else begin
                r_holdCnt <= '0;
            end
            if (r_state == COOLDOWN && w_nextState == COOLDOWN) begin
                r_coolCnt <= r_coolCnt + 1'b1;
            end else begin
                r_coolCnt <= '0;
            end
        end
    end

    assign o_move    = (r_state == ACTIVE);
    assign o_timeout = r_timeout;

endmodule

// File: rtl/flip_input_conditioner.sv
// Conditions the raw left/right flipper buttons into clean flip requests,
// using two independent copies of the button channel.
module flip_input_conditioner
    import pinball_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_MAX_CYCLES = 50000000,
    parameter int COOLDOWN_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    output logic move_left_flip,
    output logic move_right_flip,
    output logic left_timeout,
    output logic right_timeout
);

    flip_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_MAX_CYCLES (HOLD_MAX_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
    ) u_left (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn     (btn_left),
        .o_move    (move_left_flip),
        .o_timeout (left_timeout)
    );

    flip_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_MAX_CYCLES (HOLD_MAX_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
    ) u_right (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn     (btn_right),
        .o_move    (move_right_flip),
        .o_timeout (right_timeout)
    );

endmodule

// File: tb/tb_flip_input_conditioner.sv
// Directed bench for flip_input_conditioner with D=4, HOLD=20, COOL=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_flip_input_conditioner;

    logic clk;
    logic rst;
    logic btn_left;
    logic btn_right;
    logic move_left_flip;
    logic move_right_flip;
    logic left_timeout;
    logic right_timeout;

    int checks;
    int errors;

    flip_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_MAX_CYCLES (20),
        .COOLDOWN_CYCLES (8)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .move_left_flip  (move_left_flip),
        .move_right_flip (move_right_flip),
        .left_timeout    (left_timeout),
        .right_timeout   (right_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic left, input logic right);
        btn_left  = left;
        btn_right = right;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int firstRise;
    int highCnt;
    int toCnt;
    int toEdge;
    int rightHigh;
    int leftHigh;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("reset_move_left", int'(move_left_flip), 0);
        checkOutput("reset_move_right", int'(move_right_flip), 0);
        checkOutput("reset_timeout_left", int'(left_timeout), 0);
        checkOutput("reset_timeout_right", int'(right_timeout), 0);
        stepEdges(3);
        rst = 1'b0;
        stepEdges(2);

        // Left held 100 cycles: rises after edge 7, high 20 cycles, one timeout at edge 27.
        applyStimulus(1'b1, 1'b0);
        firstRise = -1;
        highCnt   = 0;
        toCnt     = 0;
        toEdge    = -1;
        rightHigh = 0;
        for (int e = 1; e <= 100; e++) begin
            stepEdges(1);
            if (move_left_flip) begin
                highCnt++;
                if (firstRise < 0) firstRise = e;
            end
            if (left_timeout) begin
                toCnt++;
                toEdge = e;
            end
            if (move_right_flip) rightHigh++;
        end
        checkOutput("hold_first_rise_edge", firstRise, 7);
        checkOutput("hold_high_cycles", highCnt, 20);
        checkOutput("hold_timeout_pulses", toCnt, 1);
        checkOutput("hold_timeout_edge", toEdge, 27);
        checkOutput("hold_right_quiet", rightHigh, 0);

        applyStimulus(1'b0, 1'b0);
        stepEdges(30);

        applyStimulus(1'b1, 1'b0);
        stepEdges(6);
        checkOutput("repress_edge6", int'(move_left_flip), 0);
        stepEdges(1);
        checkOutput("repress_edge7", int'(move_left_flip), 1);

        applyStimulus(1'b0, 1'b0);
        stepEdges(6);
        checkOutput("release_edge6", int'(move_left_flip), 1);
        stepEdges(1);
        checkOutput("release_edge7", int'(move_left_flip), 0);
        checkOutput("release_no_timeout", int'(left_timeout), 0);

        // Re-press so the debounced press lands while still in COOLDOWN.
        applyStimulus(1'b1, 1'b0);
        leftHigh = 0;
        for (int e = 1; e <= 40; e++) begin
            stepEdges(1);
            if (move_left_flip) leftHigh++;
        end
        checkOutput("cooldown_press_discarded", leftHigh, 0);
        applyStimulus(1'b0, 1'b0);
        stepEdges(30);

        applyStimulus(1'b0, 1'b1);
        stepEdges(3);
        applyStimulus(1'b0, 1'b0);
        rightHigh = 0;
        for (int e = 1; e <= 20; e++) begin
            stepEdges(1);
            if (move_right_flip) rightHigh++;
        end
        checkOutput("glitch_right_never", rightHigh, 0);
        checkOutput("glitch_debcnt_zero", int'(u_dut.u_right.r_debCnt), 0);

        applyStimulus(1'b1, 1'b1);
        stepEdges(6);
        checkOutput("both_left_edge6", int'(move_left_flip), 0);
        checkOutput("both_right_edge6", int'(move_right_flip), 0);
        stepEdges(1);
        checkOutput("both_left_edge7", int'(move_left_flip), 1);
        checkOutput("both_right_edge7", int'(move_right_flip), 1);
        applyStimulus(1'b0, 1'b1);
        stepEdges(6);
        checkOutput("both_left_rel6", int'(move_left_flip), 1);
        stepEdges(1);
        checkOutput("both_left_rel7", int'(move_left_flip), 0);
        checkOutput("both_right_kept", int'(move_right_flip), 1);
        applyStimulus(1'b0, 1'b0);
        stepEdges(50);

        applyStimulus(1'b1, 1'b0);
        stepEdges(7);
        checkOutput("rst_pre_active", int'(move_left_flip), 1);
        stepEdges(3);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_move_left", int'(move_left_flip), 0);
        checkOutput("rst_async_move_right", int'(move_right_flip), 0);
        checkOutput("rst_async_timeout_left", int'(left_timeout), 0);
        checkOutput("rst_async_timeout_right", int'(right_timeout), 0);
        stepEdges(2);
        rst = 1'b0;
        stepEdges(6);
        checkOutput("rst_reassert_edge6", int'(move_left_flip), 0);
        stepEdges(1);
        checkOutput("rst_reassert_edge7", int'(move_left_flip), 1);

        applyStimulus(1'b0, 1'b0);
        stepEdges(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flip_input_conditioner.md
FLIP_INPUT_CONDITIONER -- requirements
Module: flip_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive cycles a synchronized button level must differ from the debounced level before it is accepted; legal range >= 1.
REQ-002 Parameter HOLD_MAX_CYCLES, default 50000000, maximum number of cycles a flip request stays asserted per press; legal range >= 1.
REQ-003 Parameter COOLDOWN_CYCLES, default 5000000, number of cycles a channel ignores presses after a request ends; legal range >= 1.
REQ-004 Port clk, input, 1, base clock; the block uses this single clock for all logic.
REQ-005 Port rst, input, 1, reset; asynchronous, active-high.
REQ-006 Port btn_left, input, 1, raw left flipper button, asynchronous to clk, 1 = pressed.
REQ-007 Port btn_right, input, 1, raw right flipper button, asynchronous to clk, 1 = pressed.
REQ-008 Port move_left_flip, output, 1, left flip request to the flipper animation stage.
REQ-009 Port move_right_flip, output, 1, right flip request to the flipper animation stage.
REQ-010 Port left_timeout, output, 1, one-cycle pulse when the left request is dropped by HOLD_MAX_CYCLES expiry.
REQ-011 Port right_timeout, output, 1, one-cycle pulse when the right request is dropped by HOLD_MAX_CYCLES expiry.

Function
REQ-012 Left and right channels are identical and fully independent, including when events on both channels fall in the same cycle.
REQ-013 Each button passes through a 2-flop synchronizer before use.
REQ-014 Debounce: a counter increments each cycle the synchronized level differs from the debounced level and clears when they match; on the Dth consecutive mismatch (D = DEBOUNCE_CYCLES) the debounced level toggles and the counter clears.
REQ-015 Press event = debounced level 0->1, detected against a registered copy of the debounced level.
REQ-016 Per-channel FSM states: IDLE, ACTIVE, COOLDOWN; the move output is 1 only in ACTIVE and is decoded from the registered state.
REQ-017 IDLE -> ACTIVE on a press event; the hold counter clears.
REQ-018 ACTIVE -> COOLDOWN when the debounced level is 0 (release), or when the hold counter reaches HOLD_MAX_CYCLES-1 (timeout).
REQ-019 Release and timeout in the same cycle: treat as release; no timeout pulse.
REQ-020 Timeout pulse is registered and high exactly for the first cycle spent in COOLDOWN.
REQ-021 COOLDOWN -> IDLE after exactly COOLDOWN_CYCLES cycles in COOLDOWN.
REQ-022 Press events in COOLDOWN are discarded; a button still held on return to IDLE does not assert; a new press event is required.
REQ-023 Latency: btn rising with edge 1 as the first clk edge after the change, held stable: move asserted after edge DEBOUNCE_CYCLES+3. Release is symmetric: move deasserts after edge DEBOUNCE_CYCLES+3 from the release.
REQ-024 Counter widths are sized by $clog2 of the respective parameter plus 1; counters never wrap in any state.

Reset
REQ-025 While rst=1: synchronizer flops, debounced levels and their registered copies = 0; counters = 0; FSMs = IDLE; move_left_flip = move_right_flip = left_timeout = right_timeout = 0. These values take effect immediately, without waiting for a clk edge.
REQ-026 A button held through rst deassertion produces a fresh press event once debounced, per REQ-014/015.

Structure
REQ-027 FSM state encoding (2-bit enum IDLE/ACTIVE/COOLDOWN) resides in shared package pinball_pkg.
REQ-028 One sub-module flip_button_channel (synchronizer, debounce, FSM, counters); the top level instantiates it twice.

Verification (D=4, HOLD=20, COOL=8)
REQ-029 btn_left 0->1 before edge 1, held -> move_left_flip rises after edge 7; move_right_flip stays 0.
REQ-030 btn_right high for 3 cycles, then low -> move_right_flip never asserts; debounce counter back at 0.
REQ-031 btn_left held 100 cycles -> move_left_flip high exactly 20 cycles; left_timeout is a 1-cycle pulse on the drop; no reassert while held; release then press after cooldown -> asserts again.
REQ-032 Both buttons rise the same cycle -> both moves rise on the same edge; releasing the left one only drops move_left_flip.
REQ-033 rst pulsed mid-cycle while ACTIVE -> all outputs 0 before the next edge; button still held -> move reasserts DEBOUNCE_CYCLES+3 edges after rst release.
REQ-034 Release, then re-press 3 cycles into COOLDOWN and hold -> no assertion, including after return to IDLE.
